// File: rtl/cache_pkg.sv
// Shared types and block geometry for the instruction-cache fill path.
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int WORD_BITS         = 16;
  localparam int WORDS_PER_BLOCK   = 8;
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORD_INDEX_BITS   = 3;

  localparam logic [15:0] BLOCK_ALIGN_MASK = 16'hFFF0;

  // Byte offset of a 16-bit word within its block.
  function automatic logic [BLOCK_OFFSET_BITS-1:0] word_byte_offset(
    input logic [WORD_INDEX_BITS-1:0] idx
  );
    return {idx, 1'b0};
  endfunction

endpackage

// File: rtl/cache_word_counter.sv
// Word counter for one side of a block fill: counts 0..WORDS_PER_BLOCK, done at a full block.
// Clear takes priority over increment; the caller gates increment once done.
module cache_word_counter
  import cache_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clr,
  input  logic                       i_inc,
  output logic [WORD_INDEX_BITS-1:0] o_count,
  output logic                       o_done
);

  logic [WORD_INDEX_BITS:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count[WORD_INDEX_BITS-1:0];
  assign o_done  = (r_count == (WORD_INDEX_BITS+1)'(WORDS_PER_BLOCK));

endmodule

// File: rtl/cache_fill_fsm.sv
// Instruction-cache miss handler: reads one block back-to-back, streams returned words into the data array, then writes the tag.
// Reads start the cycle after the miss; completion follows the last returned word regardless of memory latency.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data,
  output logic                  memory_read_en,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  fsm_busy,
  output logic                  write_data_array,
  output logic [ADDR_WIDTH-1:0] fill_address,
  output logic [15:0]           fill_data,
  output logic                  write_tag_array
);

  import cache_pkg::*;

  fill_state_t                r_state;
  fill_state_t                w_next_state;
  logic [ADDR_WIDTH-1:0]      r_base;
  logic [WORD_INDEX_BITS-1:0] w_issue_idx;
  logic [WORD_INDEX_BITS-1:0] w_recv_idx;
  logic                       w_issue_done;
  logic                       w_recv_done;
  logic                       w_in_fill;
  logic                       w_last_word;

  assign w_in_fill   = (r_state == FILL);
  assign w_last_word = w_in_fill && memory_data_valid &&
                       (w_recv_idx == WORD_INDEX_BITS'(WORDS_PER_BLOCK - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Only IDLE samples the miss, so a miss held through a fill cannot move the base.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base <= '0;
    end else if ((r_state == IDLE) && miss_detected) begin
      r_base <= miss_address & ~ADDR_WIDTH'(~BLOCK_ALIGN_MASK);
    end
  end

  cache_word_counter u_issue_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (!w_in_fill),
    .i_inc   (w_in_fill && !w_issue_done),
    .o_count (w_issue_idx),
    .o_done  (w_issue_done)
  );

  cache_word_counter u_recv_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (!w_in_fill),
    .i_inc   (w_in_fill && memory_data_valid && !w_recv_done),
    .o_count (w_recv_idx),
    .o_done  (w_recv_done)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (miss_detected) w_next_state = FILL;
      FILL:    if (w_last_word)   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    memory_read_en   = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_address     = '0;
    write_tag_array  = 1'b0;
    if (w_in_fill) begin
      if (!w_issue_done) begin
        memory_read_en = 1'b1;
        memory_address = r_base + ADDR_WIDTH'(word_byte_offset(w_issue_idx));
      end
      if (memory_data_valid) begin
        write_data_array = 1'b1;
        fill_address     = r_base + ADDR_WIDTH'(word_byte_offset(w_recv_idx));
        write_tag_array  = w_last_word;
      end
    end
  end

  assign fsm_busy  = w_in_fill;
  assign fill_data = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a memory model answers reads with fixed or random in-order latency,
// and each scenario compares logged reads, writes and busy cycles against block-level expectations.
`timescale 1ns/1ps
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        memory_read_en;
  logic [15:0] memory_address;
  logic        fsm_busy;
  logic        write_data_array;
  logic [15:0] fill_address;
  logic [15:0] fill_data;
  logic        write_tag_array;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // memory model state
  int          lat_mode    = 0;   // 0: fixed 4-cycle latency, 1: in order with random 0..3 cycle gaps
  bit          stray_valid = 1'b0;
  int          last_due    = 0;
  int          pend_due[$];
  logic [15:0] pend_dat[$];

  // observation logs
  int          rd_cyc[$];
  logic [15:0] rd_addr[$];
  logic [15:0] rsp_dat[$];
  int          wr_cyc[$];
  logic [15:0] wr_addr[$];
  logic [15:0] wr_dat[$];
  bit          wr_tag[$];
  int          busy_cyc[$];
  int          tag_only = 0;

  cache_fill_fsm #(.ADDR_WIDTH(16), .WORDS_PER_BLOCK(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .memory_read_en    (memory_read_en),
    .memory_address    (memory_address),
    .fsm_busy          (fsm_busy),
    .write_data_array  (write_data_array),
    .fill_address      (fill_address),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  // Memory responder: drives one returned word per due cycle, shortly after the edge.
  initial begin
    memory_data_valid = 1'b0;
    memory_data       = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        memory_data_valid = 1'b1;
        memory_data       = pend_dat.pop_front();
        void'(pend_due.pop_front());
      end else begin
        memory_data_valid = stray_valid;
        memory_data       = 16'($urandom);
      end
    end
  end

  // Monitor: captures requests into the memory model and logs every observable event.
  always @(negedge clk) begin
    if (!rst) begin
      if (memory_read_en) begin
        int          due;
        logic [15:0] d;
        if (lat_mode == 0) begin
          due = cyc + 4;
        end else begin
          due = (last_due >= cyc) ? last_due + 1 : cyc + 1;
          due += int'($urandom_range(0, 3));
        end
        last_due = due;
        d = 16'($urandom);
        pend_due.push_back(due);
        pend_dat.push_back(d);
        rd_cyc.push_back(cyc);
        rd_addr.push_back(memory_address);
        rsp_dat.push_back(d);
      end
      if (write_data_array) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(fill_address);
        wr_dat.push_back(fill_data);
        wr_tag.push_back(write_tag_array);
      end else if (write_tag_array) begin
        tag_only++;
      end
      if (fsm_busy) busy_cyc.push_back(cyc);
    end
  end

  // Reference: word i of a block lives at the block start plus 2*i bytes.
  function automatic logic [15:0] exp_addr(input logic [15:0] miss, input int i);
    int blk;
    blk = (int'(miss) / 16) * 16;
    return 16'(blk + 2 * i);
  endfunction

  task automatic clear_logs();
    rd_cyc.delete(); rd_addr.delete(); rsp_dat.delete();
    wr_cyc.delete(); wr_addr.delete(); wr_dat.delete(); wr_tag.delete();
    busy_cyc.delete();
    tag_only = 0;
    last_due = 0;
  endtask

  task automatic start_miss(input logic [15:0] addr, output int c0);
    @(posedge clk); #1;
    miss_detected = 1'b1;
    miss_address  = addr;
    c0 = cyc;
    @(posedge clk); #1;
    miss_detected = 1'b0;
    miss_address  = 16'($urandom);
  endtask

  task automatic wait_done(output bit timed_out);
    bit saw = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #2;
      if (fsm_busy) saw = 1'b1;
      else if (saw) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_tests++;
    if ({fsm_busy, memory_read_en, write_data_array, write_tag_array} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: busy/rd/wd/wt got %b%b%b%b want 0000",
               fsm_busy, memory_read_en, write_data_array, write_tag_array);
    end
    n_tests++;
    if ({memory_address, fill_address} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_addr: mem_addr %h fill_addr %h want 0000 0000", memory_address, fill_address);
    end
    n_tests++;
    if (fill_data !== memory_data) begin
      n_fail++;
      $display("FAIL reset_fill_data: got %h want %h", fill_data, memory_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_fill();
    int c0;
    bit to;
    logic [15:0] a = 16'h1236;
    clear_logs();
    lat_mode = 0;
    start_miss(a, c0);
    wait_done(to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL basic_timeout: busy did not fall within 300 cycles, want completion"); end
    n_tests++;
    if (rd_addr.size() != 8) begin n_fail++; $display("FAIL basic_rd_count: got %0d want 8", rd_addr.size()); end
    for (int i = 0; i < rd_addr.size() && i < 8; i++) begin
      n_tests++;
      if (rd_addr[i] !== exp_addr(a, i) || rd_cyc[i] != c0 + 1 + i) begin
        n_fail++;
        $display("FAIL basic_rd[%0d]: got %h@%0d want %h@%0d", i, rd_addr[i], rd_cyc[i] - c0, exp_addr(a, i), 1 + i);
      end
    end
    n_tests++;
    if (wr_addr.size() != 8) begin n_fail++; $display("FAIL basic_wr_count: got %0d want 8", wr_addr.size()); end
    for (int i = 0; i < wr_addr.size() && i < 8; i++) begin
      n_tests++;
      if (wr_addr[i] !== exp_addr(a, i) || wr_dat[i] !== rsp_dat[i] || wr_tag[i] != (i == 7) || wr_cyc[i] != c0 + 5 + i) begin
        n_fail++;
        $display("FAIL basic_wr[%0d]: got %h/%h/tag%0d@%0d want %h/%h/tag%0d@%0d", i, wr_addr[i], wr_dat[i],
                 wr_tag[i], wr_cyc[i] - c0, exp_addr(a, i), rsp_dat[i], (i == 7), 5 + i);
      end
    end
    n_tests++;
    if (tag_only != 0) begin n_fail++; $display("FAIL basic_tag_only: got %0d want 0", tag_only); end
    n_tests++;
    if (busy_cyc.size() != 12 || busy_cyc[0] != c0 + 1 || busy_cyc[$] != c0 + 12) begin
      n_fail++;
      $display("FAIL basic_busy: got %0d cycles from %0d want 12 from 1", busy_cyc.size(),
               (busy_cyc.size() > 0) ? busy_cyc[0] - c0 : -1);
    end
  endtask

  task automatic test_irregular();
    lat_mode = 1;
    for (int t = 0; t < 3; t++) begin
      int c0;
      bit to;
      logic [15:0] a = 16'($urandom);
      clear_logs();
      start_miss(a, c0);
      wait_done(to);
      n_tests++;
      if (to || wr_addr.size() != 8) begin
        n_fail++;
        $display("FAIL irr%0d_count: timeout %0d writes %0d want 0 and 8", t, to, wr_addr.size());
      end
      for (int i = 0; i < wr_addr.size() && i < 8; i++) begin
        n_tests++;
        if (wr_addr[i] !== exp_addr(a, i) || wr_dat[i] !== rsp_dat[i] || wr_tag[i] != (i == 7)) begin
          n_fail++;
          $display("FAIL irr%0d_wr[%0d]: got %h/%h/tag%0d want %h/%h/tag%0d", t, i, wr_addr[i], wr_dat[i],
                   wr_tag[i], exp_addr(a, i), rsp_dat[i], (i == 7));
        end
      end
      n_tests++;
      if (rd_cyc.size() != 8 || rd_cyc[0] != c0 + 1 || rd_cyc[$] != c0 + 8) begin
        n_fail++;
        $display("FAIL irr%0d_reads: got %0d reads want 8 in cycles 1..8", t, rd_cyc.size());
      end
      if (wr_cyc.size() == 8) begin
        n_tests++;
        if (busy_cyc.size() != wr_cyc[7] - c0 || busy_cyc[$] != wr_cyc[7] || tag_only != 0) begin
          n_fail++;
          $display("FAIL irr%0d_busy: got %0d busy cycles, tag_only %0d want %0d and 0", t,
                   busy_cyc.size(), tag_only, wr_cyc[7] - c0);
        end
      end
    end
  endtask

  task automatic test_ignored_miss();
    int c0;
    bit to1, to2;
    logic [15:0] a1 = 16'h4A2C;
    logic [15:0] a2 = 16'h7B13;
    clear_logs();
    lat_mode = 0;
    @(posedge clk); #1;
    miss_detected = 1'b1;
    miss_address  = a1;
    c0 = cyc;
    @(posedge clk); #1;
    miss_address = a2;
    wait_done(to1);
    @(posedge clk); #1;
    miss_detected = 1'b0;
    wait_done(to2);
    n_tests++;
    if (to1 || to2 || wr_addr.size() != 16 || rd_addr.size() != 16) begin
      n_fail++;
      $display("FAIL held_count: timeouts %0d%0d writes %0d reads %0d want 00 16 16", to1, to2,
               wr_addr.size(), rd_addr.size());
    end
    for (int i = 0; i < wr_addr.size() && i < 16; i++) begin
      logic [15:0] e;
      e = (i < 8) ? exp_addr(a1, i) : exp_addr(a2, i - 8);
      n_tests++;
      if (wr_addr[i] !== e || rd_addr[i] !== e || wr_tag[i] != (i == 7 || i == 15)) begin
        n_fail++;
        $display("FAIL held_wr[%0d]: wr %h rd %h tag%0d want %h tag%0d", i, wr_addr[i], rd_addr[i],
                 wr_tag[i], e, (i == 7 || i == 15));
      end
    end
    if (rd_cyc.size() == 16 && wr_cyc.size() == 16) begin
      n_tests++;
      if (rd_cyc[0] != c0 + 1 || rd_cyc[8] != wr_cyc[7] + 2) begin
        n_fail++;
        $display("FAIL held_restart: second fill first read %0d cycles after completion, want 2",
                 rd_cyc[8] - wr_cyc[7]);
      end
    end
  endtask

  task automatic test_stray_valid();
    int c0;
    bit to;
    logic [15:0] a = 16'h0C08;
    clear_logs();
    lat_mode = 0;
    @(negedge clk);
    stray_valid = 1'b1;
    repeat (4) @(negedge clk);
    stray_valid = 1'b0;
    @(negedge clk); #2;
    n_tests++;
    if (wr_addr.size() != 0 || tag_only != 0 || busy_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL stray_idle: writes %0d tags %0d busy %0d want 0 0 0", wr_addr.size(), tag_only, busy_cyc.size());
    end
    start_miss(a, c0);
    wait_done(to);
    n_tests++;
    if (to || wr_addr.size() != 8) begin
      n_fail++;
      $display("FAIL stray_fill_count: timeout %0d writes %0d want 0 and 8", to, wr_addr.size());
    end else if (wr_addr[0] !== exp_addr(a, 0) || wr_cyc[0] != c0 + 5 || !wr_tag[7] || wr_tag[6]) begin
      n_fail++;
      $display("FAIL stray_fill_order: first %h@%0d last tag %0d want %h@5 tag 1", wr_addr[0],
               wr_cyc[0] - c0, wr_tag[7], exp_addr(a, 0));
    end
  endtask

  task automatic test_reset_mid_fill();
    int c0;
    int tags;
    bit to;
    logic [15:0] a = 16'h5A5A;
    clear_logs();
    lat_mode = 0;
    start_miss(a, c0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (wr_addr.size() >= 3) break;
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({fsm_busy, memory_read_en, write_data_array, write_tag_array} !== 4'b0 ||
        {memory_address, fill_address} !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: busy/rd/wd/wt %b%b%b%b addr %h/%h want 0000 0000/0000",
               fsm_busy, memory_read_en, write_data_array, write_tag_array, memory_address, fill_address);
    end
    pend_due.delete();
    pend_dat.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    tags = tag_only;
    foreach (wr_tag[i]) tags += int'(wr_tag[i]);
    n_tests++;
    if (wr_addr.size() != 3 || tags != 0) begin
      n_fail++;
      $display("FAIL rst_mid_partial: writes %0d tags %0d want 3 0", wr_addr.size(), tags);
    end
    clear_logs();
    start_miss(a, c0);
    wait_done(to);
    n_tests++;
    if (to || wr_addr.size() != 8) begin
      n_fail++;
      $display("FAIL rst_refill_count: timeout %0d writes %0d want 0 and 8", to, wr_addr.size());
    end else if (wr_addr[0] !== exp_addr(a, 0) || wr_addr[7] !== exp_addr(a, 7) || !wr_tag[7]) begin
      n_fail++;
      $display("FAIL rst_refill_order: first %h last %h tag %0d want %h %h 1", wr_addr[0], wr_addr[7],
               wr_tag[7], exp_addr(a, 0), exp_addr(a, 7));
    end
  endtask

  task automatic test_addr_wrap();
    int c0;
    bit to;
    logic [15:0] a = 16'hFFFE;
    clear_logs();
    lat_mode = 1;
    start_miss(a, c0);
    wait_done(to);
    n_tests++;
    if (to || rd_addr.size() != 8 || wr_addr.size() != 8) begin
      n_fail++;
      $display("FAIL wrap_count: timeout %0d reads %0d writes %0d want 0 8 8", to, rd_addr.size(), wr_addr.size());
    end
    for (int i = 0; i < rd_addr.size() && i < 8 && i < wr_addr.size(); i++) begin
      n_tests++;
      if (rd_addr[i] !== exp_addr(a, i) || wr_addr[i] !== exp_addr(a, i) || wr_tag[i] != (i == 7)) begin
        n_fail++;
        $display("FAIL wrap[%0d]: rd %h wr %h tag%0d want %h tag%0d", i, rd_addr[i], wr_addr[i], wr_tag[i],
                 exp_addr(a, i), (i == 7));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address  = '0;
    test_reset();
    test_basic_fill();
    test_irregular();
    test_ignored_miss();
    test_stray_valid();
    test_reset_mid_fill();
    test_addr_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
